spi_cmd_decoder: RTL
====================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter RD_TIMEOUT, default 15, SHALL be the number of i_sys_clk cycles to wait for read data (range 2..255).
REQ-002 i_sys_clk  in  1  SHALL be the single system clock; all logic SHALL be rising-edge on it.
REQ-003 i_rst_b  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_spi_cs_b  in  1  SHALL be the raw SPI chip select, active-low; it is asynchronous to i_sys_clk.
REQ-005 i_rx_data_valid  in  1  SHALL be the one-cycle pulse marking a received byte.
REQ-006 i_rx_byte  in  8  SHALL be the received byte, valid with i_rx_data_valid.
REQ-007 o_tx_data_valid  out  1  SHALL be the one-cycle pulse that loads o_tx_byte into the SPI transmitter.
REQ-008 o_tx_byte  out  8  SHALL be the byte to be shifted out on MISO.
REQ-009 o_ioc  out  2  SHALL be the target select decoded from the opcode.
REQ-010 o_addr  out  5  SHALL be the current register address.
REQ-011 o_wr_en  out  1  SHALL be the one-cycle register write strobe.
REQ-012 o_wr_data  out  8  SHALL be the write data, valid with o_wr_en.
REQ-013 o_rd_req  out  1  SHALL be the one-cycle register read request.
REQ-014 i_rd_data  in  8  SHALL be the read data, valid with i_rd_valid.
REQ-015 i_rd_valid  in  1  SHALL be the read-data-valid pulse.
REQ-016 o_err  out  1  SHALL be the sticky error flag (read timeout or overrun), cleared only by reset.

Function
REQ-017 i_spi_cs_b SHALL pass through a 2-flop synchronizer; "frame active" SHALL mean the synchronized value is 0.
REQ-018 Opcode byte (first byte of a frame) SHALL decode as: bit7 = write(1)/read(0), bits6:5 = o_ioc, bits4:0 = o_addr.
REQ-019 States SHALL be IDLE, WR_DATA, RD_WAIT and RD_DATA.
REQ-020 IDLE: rx_valid while the frame is active SHALL latch o_ioc/o_addr on the next edge; write -> WR_DATA; read -> RD_WAIT with o_rd_req pulsed at N+1 (N = rx_valid cycle).
REQ-021 WR_DATA: each rx_valid at cycle M SHALL produce o_wr_en=1 and o_wr_data=byte at M+1, with o_addr unchanged during the strobe; o_addr SHALL increment by 1 the cycle after the strobe, wrapping 31->0.
REQ-022 RD_WAIT: i_rd_valid at cycle K SHALL drive o_tx_byte=i_rd_data and o_tx_data_valid=1 at K+1, then go to RD_DATA.
REQ-023 o_addr SHALL be held stable from the o_rd_req pulse until i_rd_valid or timeout.
REQ-024 RD_WAIT timeout: if no i_rd_valid arrives within RD_TIMEOUT cycles after o_rd_req, the block SHALL drive o_tx_byte=0xEE with o_tx_data_valid pulsed, set o_err, and go to RD_DATA.
REQ-025 RD_DATA: rx_valid (dummy byte) SHALL increment o_addr (wrap 31->0) and pulse o_rd_req 1 cycle later -> RD_WAIT (burst read).
REQ-026 rx_valid in RD_WAIT SHALL be an overrun: the byte is discarded, o_err is set, and the state is unchanged.
REQ-027 i_rd_valid outside RD_WAIT SHALL be ignored.
REQ-028 Frame end (synchronized CS high) SHALL return the state to IDLE on the next edge and set o_tx_byte to 0x00; any pending read SHALL be abandoned without a tx pulse.
REQ-029 rx_valid coincident with the detected frame end SHALL be processed as follows: a WR_DATA write still executes; in RD_DATA no o_rd_req is issued; in IDLE it is ignored.
REQ-030 o_tx_byte SHALL be 0x00 whenever no read data is pending.
REQ-031 o_wr_en, o_rd_req and o_tx_data_valid SHALL each be high for one cycle per event, and o_wr_en and o_rd_req SHALL never be high together.

Reset
REQ-032 While i_rst_b=0, all outputs SHALL be 0 (o_tx_byte=0x00, o_addr=0, o_ioc=0, o_err=0), the state SHALL be IDLE, and the synchronizer SHALL be set to 1 (CS inactive).
REQ-033 Reset asserted mid-frame SHALL take effect immediately; after release, bytes SHALL be ignored until a CS-high then CS-low transition.

Verification
REQ-034 Frame of bytes 0x85, 0xA5, 0x3C -> o_wr_en pulses at addr 5 data 0xA5 and at addr 6 data 0x3C, with o_ioc=0.
REQ-035 Frame of bytes 0x5F, dummy, dummy; i_rd_valid returns 0x11 then 0x22 -> o_rd_req at addr 31 then addr 0 (wrap), and o_tx_byte 0x11 then 0x22 with one o_tx_data_valid pulse each.
REQ-036 Read opcode 0x03 with i_rd_valid never asserted -> after RD_TIMEOUT cycles, o_tx_byte=0xEE with o_tx_data_valid pulsed, and o_err=1.
REQ-037 Second rx_valid during RD_WAIT -> byte dropped, o_err=1, and no extra o_rd_req.
REQ-038 CS deasserted during RD_WAIT, then late i_rd_valid -> state IDLE, no tx pulse, and o_tx_byte=0x00.
REQ-039 Reset pulsed during WR_DATA -> all outputs 0, and the next byte in the same CS-low frame is ignored.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns opcode/data bytes from an SPI slave into
// register write strobes and read requests, with burst and timeout handling.
module spi_cmd_decoder #(
  parameter int RD_TIMEOUT = 15
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic       i_spi_cs_b,
  input  logic       i_rx_data_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_data_valid,
  output logic [7:0] o_tx_byte,
  output logic [1:0] o_ioc,
  output logic [4:0] o_addr,
  output logic       o_wr_en,
  output logic [7:0] o_wr_data,
  output logic       o_rd_req,
  input  logic [7:0] i_rd_data,
  input  logic       i_rd_valid,
  output logic       o_err
);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_WAIT,
    RD_DATA
  } state_t;

  state_t     state, state_d;
  logic       cs_meta, cs_sync;
  logic [1:0] settle;
  logic       armed;
  logic       frame;
  logic [7:0] tmr, tmr_d;
  logic       rd_pend, rd_pend_d;
  logic [1:0] ioc_d;
  logic [4:0] addr_d;
  logic       wr_en_d, rd_req_d, tx_valid_d, err_d;
  logic [7:0] wr_data_d, tx_byte_d;

  // Frames count only after CS has been seen high once the chain has
  // flushed, so a reset inside a frame mutes the rest of that frame.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      settle  <= 2'b00;
      armed   <= 1'b0;
    end else begin
      cs_meta <= i_spi_cs_b;
      cs_sync <= cs_meta;
      settle  <= {settle[0], 1'b1};
      if (settle[1] && cs_sync) armed <= 1'b1;
    end
  end

  assign frame = armed & ~cs_sync;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state           <= IDLE;
      tmr             <= '0;
      rd_pend         <= 1'b0;
      o_ioc           <= '0;
      o_addr          <= '0;
      o_wr_en         <= 1'b0;
      o_wr_data       <= '0;
      o_rd_req        <= 1'b0;
      o_tx_data_valid <= 1'b0;
      o_tx_byte       <= '0;
      o_err           <= 1'b0;
    end else begin
      state           <= state_d;
      tmr             <= tmr_d;
      rd_pend         <= rd_pend_d;
      o_ioc           <= ioc_d;
      o_addr          <= addr_d;
      o_wr_en         <= wr_en_d;
      o_wr_data       <= wr_data_d;
      o_rd_req        <= rd_req_d;
      o_tx_data_valid <= tx_valid_d;
      o_tx_byte       <= tx_byte_d;
      o_err           <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    tmr_d      = tmr;
    rd_pend_d  = 1'b0;
    ioc_d      = o_ioc;
    addr_d     = o_addr;
    wr_en_d    = 1'b0;
    wr_data_d  = o_wr_data;
    rd_req_d   = 1'b0;
    tx_valid_d = 1'b0;
    tx_byte_d  = o_tx_byte;
    err_d      = o_err;
    // Post-increment lands the cycle after each write strobe.
    if (o_wr_en) addr_d = o_addr + 5'd1;
    if (!frame) begin
      state_d   = IDLE;
      tx_byte_d = '0;
      if (state == WR_DATA && i_rx_data_valid) begin
        wr_en_d   = 1'b1;
        wr_data_d = i_rx_byte;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (i_rx_data_valid) begin
            ioc_d  = i_rx_byte[6:5];
            addr_d = i_rx_byte[4:0];
            if (i_rx_byte[7]) begin
              state_d = WR_DATA;
            end else begin
              state_d  = RD_WAIT;
              rd_req_d = 1'b1;
              tmr_d    = '0;
            end
          end
        end
        WR_DATA: begin
          if (i_rx_data_valid) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_rx_byte;
          end
        end
        RD_WAIT: begin
          tmr_d = tmr + 8'd1;
          if (i_rx_data_valid) err_d = 1'b1;
          if (i_rd_valid) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = i_rd_data;
            state_d    = RD_DATA;
          end else if (tmr == 8'(RD_TIMEOUT)) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = 8'hEE;
            err_d      = 1'b1;
            state_d    = RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_pend) begin
            rd_req_d = 1'b1;
            tmr_d    = '0;
            state_d  = RD_WAIT;
          end else if (i_rx_data_valid) begin
            addr_d    = o_addr + 5'd1;
            rd_pend_d = 1'b1;
            tx_byte_d = '0;
          end
        end
      endcase
    end
  end

endmodule
